// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync header, MSB-first payload, then an even-parity bit.
// Moore FSM; data_out comes from a flop, so the first sync bit appears one cycle after acceptance.
module seq_frame_tx #(
    parameter int                DATA_W = 8,
    parameter int                SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = 4'b0110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              in_ready,
    output logic              data_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAX_W   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_W   = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int SHIFT_W = SYNC_W + DATA_W;

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_PAR
    } StateE;

    StateE              state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               parity_q, parity_d;
    logic               dataOut_q, dataOut_d;
    logic               accept;

    assign accept = in_valid && (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)              state_d = ST_SYNC;
            ST_SYNC: if (cnt_q == SYNC_LAST)  state_d = ST_DATA;
            ST_DATA: if (cnt_q == DATA_LAST)  state_d = ST_PAR;
            ST_PAR:                           state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        frame_done = (state_q == ST_PAR);
    end

    // Sync header and payload share one shift register; its MSB is always the next bit to send.
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        shift_d  = shift_q;
        parity_d = parity_q;
        if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_PAR)) begin
            cnt_d = '0;
        end
        if (accept) begin
            shift_d  = {SYNC, data_in};
            parity_d = ^data_in;
        end else if ((state_q == ST_SYNC) || (state_q == ST_DATA)) begin
            shift_d = shift_q << 1;
        end
    end

    always_comb begin
        dataOut_d = 1'b1;
        unique case (state_d)
            ST_IDLE: dataOut_d = 1'b1;
            ST_SYNC: dataOut_d = shift_d[SHIFT_W-1];
            ST_DATA: dataOut_d = shift_d[SHIFT_W-1];
            ST_PAR:  dataOut_d = parity_d;
            default: dataOut_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            dataOut_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            dataOut_q <= dataOut_d;
        end
    end

    assign data_out = dataOut_q;

endmodule
